fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage feeding the IF/ID boundary of the 5-stage RV32 pipeline. It owns the fetch PC, runs a req/ack handshake with instruction memory, and holds the IF/ID pipeline register (PC, instruction, valid) consumed by decode. It detects load-use hazards against the load currently in EX and raises `stall_id` so decode inserts a bubble into ID/EX. It also accepts branch/jump redirects resolved in EX, flushes, and drains any in-flight fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000: first fetch address after reset.
- `clk`  in  1: single clock, all state updates on posedge.
- `reset`  in  1: synchronous, active-low; sampled on posedge `clk`.
- `imem_req`  out  1: fetch request; held high with stable `imem_addr` until `imem_ack`.
- `imem_addr`  out  32: word-aligned fetch address.
- `imem_ack`  in  1: `imem_rdata` valid this cycle; only meaningful while `imem_req`=1; may coincide with the first `imem_req` cycle (zero-wait).
- `imem_rdata`  in  32: fetched instruction.
- `ex_ld`  in  1: instruction now in EX is a load (ID/EX `ld`).
- `ex_rd`  in  5: destination of instruction now in EX (ID/EX `rd`).
- `redirect`  in  1: taken branch/jump resolved in EX.
- `redirect_pc`  in  32: target when `redirect`=1.
- `PC`  out  32: IF/ID PC.
- `instr`  out  32: IF/ID instruction.
- `valid`  out  1: IF/ID holds a real instruction; decode emits zero control when 0.
- `stall_id`  out  1: load-use stall; decode inserts bubble into ID/EX, IF/ID holds.

## Operation
- Registers: `fetch_pc`, `drain_addr`, IF/ID {`PC`,`instr`,`valid`}, one-entry skid {`buf_pc`,`buf_instr`}, state.
- `stall_id` = `valid` & `ex_ld` & (`ex_rd`≠0) & (`ex_rd`==`instr[19:15]` | `ex_rd`==`instr[24:20]`). Both fields compared regardless of format; false stalls are accepted.
- `adv` = !`stall_id`.
- FETCH: `imem_req`=1, `imem_addr`=`fetch_pc`.
  - ack & adv: IF/ID ← {`fetch_pc`, rdata, 1}; `fetch_pc`+=4.
  - ack & stall: skid ← {`fetch_pc`, rdata}; `fetch_pc`+=4; → HOLD.
  - no ack & adv: `valid`←0.
  - no ack & stall: IF/ID holds.
- HOLD: `imem_req`=0. adv: IF/ID ← {skid, 1}; → FETCH. Stall: hold.
- DRAIN: `imem_req`=1, `imem_addr`=`drain_addr`. `valid`=0. On ack, discard rdata → FETCH.
- Redirect has priority over stall and ack in every state:
  - `valid`←0; skid discarded; `fetch_pc`←`redirect_pc`.
  - FETCH without ack: `drain_addr`←`fetch_pc`, → DRAIN.
  - FETCH with ack: rdata discarded, → FETCH.
  - HOLD: → FETCH.
  - DRAIN: target updated, stay DRAIN; an ack in that same cycle → FETCH.
- `stall_id` with `valid`=0 is impossible by construction.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 0. `redirect_pc[1:0]` is ignored (forced 0).

## Timing
- Reset (`reset`=0 at posedge): state=FETCH, `fetch_pc`=`RESET_PC`, `PC`=0, `instr`=32'h0000_0013 (NOP), `valid`=0, skid empty.
  - Hence `imem_req`=1, `imem_addr`=`RESET_PC`, `stall_id`=0 in the first cycle after reset.
  - Reset mid-request abandons it. Instruction memory shares reset, so no stale ack follows.
- `imem_req`/`imem_addr` depend on registered state only; `stall_id` is combinational from IF/ID and `ex_*`.
- Zero-wait memory: 1 instruction/cycle. IF/ID valid 1 cycle after ack.
- Load-use: exactly one stall cycle (ID/EX bubble clears `ex_ld`).
- Redirect penalty: redirect cycle plus the memory latency of the target. With zero-wait memory, the target appears in IF/ID 2 cycles after the redirect edge. Add drain cycles if a fetch was in flight.

## Test plan
- Reset, `RESET_PC`=0x100, zero-wait memory → `imem_addr` 0x100,0x104,0x108 on consecutive cycles; `PC`/`valid` follow one cycle later; reset values match spec.
- IF/ID=`lw`-dependent `add x3,x1,x2` with `ex_ld`=1, `ex_rd`=1 → `stall_id`=1 for one cycle; the ack arriving that cycle goes to skid; next cycle IF/ID takes skid, fetch resumes at +4, no instruction lost or duplicated. Same case with `ex_rd`=0 → no stall.
- 3-cycle memory latency, redirect to 0x400 in cycle 1 of a request to 0x20 → `imem_addr` held 0x20 until ack, data discarded, `valid`=0 throughout, next request 0x400.
- Redirect coincident with stall and ack → flush wins: `valid`=0, skid empty, next `imem_addr`=`redirect_pc`.
- `fetch_pc`=0xFFFF_FFFC acked → next `imem_addr`=0x0; `redirect_pc`=0x203 → fetch 0x200.
- Reset asserted in HOLD with skid full → next cycle FETCH at `RESET_PC`, `valid`=0, skid instruction never appears.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the fetch PC, handshakes with instruction
// memory, holds the IF/ID register and flags load-use hazards to decode.
// A one-entry skid catches an instruction acked while decode is stalled.
// DRAIN waits out a fetch that a redirect abandoned mid-request.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        ex_ld,
    input  logic [4:0]  ex_rd,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] PC,
    output logic [31:0] instr,
    output logic        valid,
    output logic        stall_id
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {S_FETCH, S_HOLD, S_DRAIN} state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;
    logic [31:0] drain_addr, drain_addr_n;
    logic [31:0] buf_pc, buf_pc_n;
    logic [31:0] buf_instr, buf_instr_n;
    logic [31:0] pc_n, instr_n;
    logic        valid_n;
    logic        ack;
    logic        adv;

    // Load-use hazard: both source fields compared regardless of format.
    always_comb begin
        stall_id = valid & ex_ld & (ex_rd != 5'd0) &
                   ((ex_rd == instr[19:15]) | (ex_rd == instr[24:20]));
    end

    // Memory request is a function of registered state only.
    always_comb begin
        imem_req  = (state != S_HOLD);
        imem_addr = (state == S_DRAIN) ? drain_addr : fetch_pc;
        ack       = imem_ack & imem_req;
        adv       = ~stall_id;
    end

    // Next-state and next register values; redirect overrides stall and ack.
    always_comb begin
        state_n      = state;
        fetch_pc_n   = fetch_pc;
        drain_addr_n = drain_addr;
        buf_pc_n     = buf_pc;
        buf_instr_n  = buf_instr;
        pc_n         = PC;
        instr_n      = instr;
        valid_n      = valid;
        if (redirect) begin
            valid_n    = 1'b0;
            fetch_pc_n = redirect_pc & ~32'h3;
            case (state)
                S_FETCH: begin
                    if (!ack) begin
                        drain_addr_n = fetch_pc;
                        state_n      = S_DRAIN;
                    end
                end
                S_HOLD:  state_n = S_FETCH;
                S_DRAIN: if (ack) state_n = S_FETCH;
                default: state_n = S_FETCH;
            endcase
        end else begin
            case (state)
                S_FETCH: begin
                    if (ack) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        if (adv) begin
                            pc_n    = fetch_pc;
                            instr_n = imem_rdata;
                            valid_n = 1'b1;
                        end else begin
                            buf_pc_n    = fetch_pc;
                            buf_instr_n = imem_rdata;
                            state_n     = S_HOLD;
                        end
                    end else if (adv) begin
                        valid_n = 1'b0;
                    end
                end
                S_HOLD: begin
                    if (adv) begin
                        pc_n    = buf_pc;
                        instr_n = buf_instr;
                        valid_n = 1'b1;
                        state_n = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    valid_n = 1'b0;
                    if (ack) state_n = S_FETCH;
                end
                default: state_n = S_FETCH;
            endcase
        end
    end

    // State and pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= S_FETCH;
            fetch_pc   <= RESET_PC;
            drain_addr <= RESET_PC;
            buf_pc     <= 32'd0;
            buf_instr  <= NOP;
            PC         <= 32'd0;
            instr      <= NOP;
            valid      <= 1'b0;
        end else begin
            state      <= state_n;
            fetch_pc   <= fetch_pc_n;
            drain_addr <= drain_addr_n;
            buf_pc     <= buf_pc_n;
            buf_instr  <= buf_instr_n;
            PC         <= pc_n;
            instr      <= instr_n;
            valid      <= valid_n;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a per-cycle vector table covering reset,
// streaming, load-use stall, redirects, drain and PC wrap, then a hand
// sequence with a three-cycle memory and a redirect mid-request.
module tb_fetch_stage;

    localparam logic [31:0] ADD = 32'h0020_81B3; // add x3,x1,x2
    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] I0  = 32'h1000_0000;
    localparam logic [31:0] I1  = 32'h2000_0000;
    localparam logic [31:0] I2  = 32'h3000_0000;
    localparam logic [31:0] I4  = 32'h4000_0000;
    localparam logic [31:0] I7  = 32'h7000_0000;
    localparam logic [31:0] I8  = 32'h8000_0000;
    localparam logic [31:0] I9  = 32'h9000_0000;
    localparam logic [31:0] JNK = 32'hDEAD_BEEF;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        ex_ld;
    logic [4:0]  ex_rd;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] PC;
    logic [31:0] instr;
    logic        valid;
    logic        stall_id;

    int n_chk  = 0;
    int n_fail = 0;

    fetch_stage #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .ex_ld(ex_ld), .ex_rd(ex_rd),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .PC(PC), .instr(instr), .valid(valid), .stall_id(stall_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst_n;
        logic        ack;
        logic [31:0] rdata;
        logic        ld;
        logic [4:0]  rd;
        logic        redir;
        logic [31:0] rpc;
        logic        chk;
        logic        e_req;
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        logic        e_valid;
        logic        e_stall;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rst_n, logic ack, logic [31:0] rdata,
                                logic ld, logic [4:0] rd, logic redir,
                                logic [31:0] rpc, logic chk, logic e_req,
                                logic [31:0] e_addr, logic [31:0] e_pc,
                                logic [31:0] e_instr, logic e_valid,
                                logic e_stall);
        vec_t v;
        v.rst_n = rst_n; v.ack = ack; v.rdata = rdata; v.ld = ld; v.rd = rd;
        v.redir = redir; v.rpc = rpc; v.chk = chk; v.e_req = e_req;
        v.e_addr = e_addr; v.e_pc = e_pc; v.e_instr = e_instr;
        v.e_valid = e_valid; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic cmp(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rst_n, input logic ack,
                         input logic [31:0] rdata, input logic ld,
                         input logic [4:0] rd, input logic redir,
                         input logic [31:0] rpc);
        @(negedge clk);
        reset = rst_n; imem_ack = ack; imem_rdata = rdata;
        ex_ld = ld; ex_rd = rd; redirect = redir; redirect_pc = rpc;
        #1;
    endtask

    task automatic check_out(input string tag, input logic e_req,
                             input logic [31:0] e_addr, input logic [31:0] e_pc,
                             input logic [31:0] e_instr, input logic e_valid,
                             input logic e_stall);
        cmp({tag, " imem_req"}, {31'd0, imem_req}, {31'd0, e_req});
        if (e_req) cmp({tag, " imem_addr"}, imem_addr, e_addr);
        cmp({tag, " PC"}, PC, e_pc);
        cmp({tag, " instr"}, instr, e_instr);
        cmp({tag, " valid"}, {31'd0, valid}, {31'd0, e_valid});
        cmp({tag, " stall_id"}, {31'd0, stall_id}, {31'd0, e_stall});
    endtask

    initial begin
        reset = 1'b0; imem_ack = 1'b0; imem_rdata = 32'd0; ex_ld = 1'b0;
        ex_rd = 5'd0; redirect = 1'b0; redirect_pc = 32'd0;

        //        rst ack rdata ld rd redir rpc            chk req addr           PC             instr  vld stl
        tv.push_back(mk(0, 0, 0,   0, 0, 0, 0,            0, 0, 0,             0,             0,     0, 0));
        tv.push_back(mk(0, 0, 0,   0, 0, 0, 0,            1, 1, 32'h100,       0,             NOP,   0, 0));
        tv.push_back(mk(1, 1, I0,  0, 0, 0, 0,            1, 1, 32'h100,       0,             NOP,   0, 0));
        tv.push_back(mk(1, 1, I1,  0, 0, 0, 0,            1, 1, 32'h104,       32'h100,       I0,    1, 0));
        tv.push_back(mk(1, 1, I2,  0, 0, 0, 0,            1, 1, 32'h108,       32'h104,       I1,    1, 0));
        tv.push_back(mk(1, 1, ADD, 0, 0, 0, 0,            1, 1, 32'h10C,       32'h108,       I2,    1, 0));
        // load-use: ack goes to skid
        tv.push_back(mk(1, 1, I4,  1, 1, 0, 0,            1, 1, 32'h110,       32'h10C,       ADD,   1, 1));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 0, 0,             32'h10C,       ADD,   1, 0));
        tv.push_back(mk(1, 1, ADD, 0, 0, 0, 0,            1, 1, 32'h114,       32'h110,       I4,    1, 0));
        // ex_rd = x0 never stalls
        tv.push_back(mk(1, 0, JNK, 1, 0, 0, 0,            1, 1, 32'h118,       32'h114,       ADD,   1, 0));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 1, 32'h118,       32'h114,       ADD,   0, 0));
        // redirect with fetch in flight: drain 0x118
        tv.push_back(mk(1, 0, JNK, 0, 0, 1, 32'h400,      1, 1, 32'h118,       32'h114,       ADD,   0, 0));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 1, 32'h118,       32'h114,       ADD,   0, 0));
        tv.push_back(mk(1, 1, JNK, 0, 0, 0, 0,            1, 1, 32'h118,       32'h114,       ADD,   0, 0));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 1, 32'h400,       32'h114,       ADD,   0, 0));
        tv.push_back(mk(1, 1, ADD, 0, 0, 0, 0,            1, 1, 32'h400,       32'h114,       ADD,   0, 0));
        // redirect + stall + ack: flush wins, low bits of target dropped
        tv.push_back(mk(1, 1, JNK, 1, 2, 1, 32'h203,      1, 1, 32'h404,       32'h400,       ADD,   1, 1));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 1, 32'h200,       32'h400,       ADD,   0, 0));
        tv.push_back(mk(1, 1, I7,  0, 0, 0, 0,            1, 1, 32'h200,       32'h400,       ADD,   0, 0));
        // redirect to top of address space
        tv.push_back(mk(1, 0, JNK, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 32'h204,      32'h200,       I7,    1, 0));
        tv.push_back(mk(1, 1, JNK, 0, 0, 0, 0,            1, 1, 32'h204,       32'h200,       I7,    0, 0));
        tv.push_back(mk(1, 1, I8,  0, 0, 0, 0,            1, 1, 32'hFFFF_FFFC, 32'h200,       I7,    0, 0));
        // wrapped to 0; redirect again -> drain 0
        tv.push_back(mk(1, 0, JNK, 0, 0, 1, 32'h300,      1, 1, 32'h0,         32'hFFFF_FFFC, I8,    1, 0));
        // redirect while draining with coincident ack
        tv.push_back(mk(1, 1, JNK, 0, 0, 1, 32'h500,      1, 1, 32'h0,         32'hFFFF_FFFC, I8,    0, 0));
        tv.push_back(mk(1, 1, ADD, 0, 0, 0, 0,            1, 1, 32'h500,       32'hFFFF_FFFC, I8,    0, 0));
        // enter HOLD with skid full, then reset there
        tv.push_back(mk(1, 1, I9,  1, 1, 0, 0,            1, 1, 32'h504,       32'h500,       ADD,   1, 1));
        tv.push_back(mk(0, 0, JNK, 1, 1, 0, 0,            1, 0, 0,             32'h500,       ADD,   1, 1));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 1, 32'h100,       0,             NOP,   0, 0));
        tv.push_back(mk(1, 1, I0,  0, 0, 0, 0,            1, 1, 32'h100,       0,             NOP,   0, 0));
        tv.push_back(mk(1, 0, JNK, 0, 0, 0, 0,            1, 1, 32'h104,       32'h100,       I0,    1, 0));

        foreach (tv[i]) begin
            drive(tv[i].rst_n, tv[i].ack, tv[i].rdata, tv[i].ld, tv[i].rd,
                  tv[i].redir, tv[i].rpc);
            if (tv[i].chk)
                check_out($sformatf("vec%0d", i), tv[i].e_req, tv[i].e_addr,
                          tv[i].e_pc, tv[i].e_instr, tv[i].e_valid,
                          tv[i].e_stall);
        end

        // Three-cycle memory, redirect to 0x400 in cycle 1 of a request to 0x20.
        drive(0, 0, JNK, 0, 0, 0, 0);
        drive(1, 0, JNK, 0, 0, 1, 32'h20);               // abandon 0x100
        check_out("seq rst", 1, 32'h100, 0, NOP, 0, 0);
        drive(1, 1, JNK, 0, 0, 0, 0);                    // drain 0x100 acks
        check_out("seq drain100", 1, 32'h100, 0, NOP, 0, 0);
        drive(1, 0, JNK, 0, 0, 1, 32'h400);              // cycle 1 of 0x20
        check_out("seq req20 c1", 1, 32'h20, 0, NOP, 0, 0);
        drive(1, 0, JNK, 0, 0, 0, 0);
        check_out("seq req20 c2", 1, 32'h20, 0, NOP, 0, 0);
        drive(1, 1, JNK, 0, 0, 0, 0);                    // late ack, discarded
        check_out("seq req20 c3", 1, 32'h20, 0, NOP, 0, 0);
        drive(1, 1, I1, 0, 0, 0, 0);
        check_out("seq req400", 1, 32'h400, 0, NOP, 0, 0);
        drive(1, 0, JNK, 0, 0, 0, 0);
        check_out("seq tgt", 1, 32'h404, 32'h400, I1, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
